// File: rtl/line_window_3x3.sv
// 3x3 neighbourhood window generator for a raster pixel stream.
// Two line buffers hold the previous two lines; a column/row tracker tags each
// accepted pixel and flags windows whose centre lies off the frame border.
module line_window_3x3 #(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned DATA_W     = 12
) (
  input  logic                          clk,
  input  logic                          pclk,
  input  logic                          in_valid,
  input  logic                          in_sof,
  input  logic [DATA_W-1:0]             in_data,
  output logic [DATA_W-1:0]             data_00_o,
  output logic [DATA_W-1:0]             data_01_o,
  output logic [DATA_W-1:0]             data_02_o,
  output logic [DATA_W-1:0]             data_10_o,
  output logic [DATA_W-1:0]             data_11_o,
  output logic [DATA_W-1:0]             data_12_o,
  output logic [DATA_W-1:0]             data_20_o,
  output logic [DATA_W-1:0]             data_21_o,
  output logic [DATA_W-1:0]             data_22_o,
  output logic                          out_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_y
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] XLast = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0] col_q, col_d, cur_col;
  logic [YW-1:0] row_q, row_d, cur_row;
  logic          accept;
  logic          win_valid;

  logic [DATA_W-1:0] lb0_q [IMG_WIDTH];
  logic [DATA_W-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  logic [DATA_W-1:0] win_q [3][3];
  logic              out_valid_q;
  logic [XW-1:0]     out_x_q;
  logic [YW-1:0]     out_y_q;

  // Effective coordinate of the incoming pixel and next counter state.
  always_comb begin
    accept  = in_valid;
    cur_col = in_sof ? '0 : col_q;
    cur_row = in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      if (cur_col == XLast) begin
        col_d = '0;
        row_d = (cur_row == YLast) ? '0 : cur_row + YW'(1);
      end else begin
        col_d = cur_col + XW'(1);
        row_d = cur_row;
      end
    end
    // Columns 0-1 still carry the previous line's tail, so they never qualify.
    win_valid = accept && (cur_col >= XW'(2)) && (cur_row >= YW'(2));
  end

  // Asynchronous read of both line buffers at the incoming column.
  always_comb begin
    lb0_rd = lb0_q[cur_col];
    lb1_rd = lb1_q[cur_col];
  end

  // Column/row tracker.
  always_ff @(posedge clk or posedge pclk) begin
    if (pclk) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffer write (read-before-write); contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept && !pclk) begin
      lb1_q[cur_col] <= lb0_rd;
      lb0_q[cur_col] <= in_data;
    end
  end

  // Window shift register plus valid pulse and centre coordinate.
  always_ff @(posedge clk or posedge pclk) begin
    if (pclk) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      out_valid_q <= win_valid;
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= win_q[i][2];
        end
        win_q[0][2] <= lb1_rd;
        win_q[1][2] <= lb0_rd;
        win_q[2][2] <= in_data;
      end
      if (win_valid) begin
        out_x_q <= cur_col - XW'(1);
        out_y_q <= cur_row - YW'(1);
      end
    end
  end

  assign data_00_o = win_q[0][0];
  assign data_01_o = win_q[0][1];
  assign data_02_o = win_q[0][2];
  assign data_10_o = win_q[1][0];
  assign data_11_o = win_q[1][1];
  assign data_12_o = win_q[1][2];
  assign data_20_o = win_q[2][0];
  assign data_21_o = win_q[2][1];
  assign data_22_o = win_q[2][2];
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

endmodule
